// File: rtl/regwr_pkg.sv
// Shared register-file constants and types for the writeback path and decode.
package regwr_pkg;

    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int NREGS    = 16;
    localparam int NREQ_MAX = 8;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        rr_next = ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/regwr_arbiter_rr.sv
// Purely combinational round-robin arbiter: search starts at ptr_i and wraps.
// The pointer register lives with the caller so this block can be reused.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;
    logic          hit_s;
    logic          found_s;

    // Walk the N candidates in priority order; the first valid one wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_i} + (IW+1)'(k);
            sum_s = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
            idx_s = sum_s[IW-1:0];
            hit_s = req_i[idx_s] & ~found_s;
            gnt_o[idx_s] = hit_s;
            gnt_idx_o    = hit_s ? idx_s : gnt_idx_o;
            found_s      = found_s | hit_s;
        end
        gnt_any_o = found_s;
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin arbitration of writeback sources onto the single register-file
// write port. Define REGWR_BYPASS_EN to forward the in-flight write to the reads.
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [AW*NREQ-1:0] req_dst_i,
    input  logic [DW*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               wr_we_o,
    output logic [AW-1:0]      wr_dst_o,
    output logic [DW-1:0]      wr_data_o,
    input  logic [AW-1:0]      rd_src0_i,
    input  logic [AW-1:0]      rd_src1_i,
    input  logic [DW-1:0]      rf_data0_i,
    input  logic [DW-1:0]      rf_data1_i,
    output logic [DW-1:0]      byp_data0_o,
    output logic [DW-1:0]      byp_data1_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_we_q, wr_we_d;
    reg_addr_t       wr_dst_q, wr_dst_d;
    reg_data_t       wr_data_q, wr_data_d;

    logic [NREQ-1:0] arb_req_s;
    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   gnt_idx_s;
    logic            gnt_any_s;
    reg_addr_t       dst_arr_s  [NREQ];
    reg_data_t       data_arr_s [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign dst_arr_s[i]  = req_dst_i[i*AW +: AW];
        assign data_arr_s[i] = req_data_i[i*DW +: DW];
    end

    // Masking at the arbiter input guarantees no grant during reset or freeze.
    assign arb_req_s = (rst_i || hold_i) ? '0 : req_valid_i;

    rr_arbiter #(
        .N  (NREQ),
        .IW (PW)
    ) u_rr (
        .req_i     (arb_req_s),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_any_o (gnt_any_s)
    );

    assign req_ready_o = gnt_s;

    // Next-state: a grant loads the write stage and advances the pointer.
    always_comb begin
        ptr_d     = ptr_q;
        wr_we_d   = 1'b0;
        wr_dst_d  = wr_dst_q;
        wr_data_d = wr_data_q;
        if (gnt_any_s) begin
            ptr_d     = PW'(rr_next(32'(gnt_idx_s), 32'(NREQ)));
            wr_we_d   = 1'b1;
            wr_dst_d  = dst_arr_s[gnt_idx_s];
            wr_data_d = data_arr_s[gnt_idx_s];
        end else begin
            ptr_d     = ptr_q;
            wr_we_d   = 1'b0;
        end
    end

    // Pointer and write-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            wr_we_q   <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_we_q   <= wr_we_d;
            wr_dst_q  <= wr_dst_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_we_o   = wr_we_q;
    assign wr_dst_o  = wr_dst_q;
    assign wr_data_o = wr_data_q;

`ifdef REGWR_BYPASS_EN
    assign byp_data0_o = (wr_we_q && (wr_dst_q == rd_src0_i)) ? wr_data_q : rf_data0_i;
    assign byp_data1_o = (wr_we_q && (wr_dst_q == rd_src1_i)) ? wr_data_q : rf_data1_i;
`else
    // Without forwarding the read addresses are not needed here.
    logic unused_rd_src_s;
    assign unused_rd_src_s = ^{rd_src0_i, rd_src1_i};
    assign byp_data0_o     = rf_data0_i;
    assign byp_data1_o     = rf_data1_i;
`endif

endmodule
